led_seq_ctrl: RTL
=================

# led_seq_ctrl

Sequencer for the 4-LED running-light display. It owns the step timer and pattern state, and takes two active-low push-buttons: one cycles the step speed (1 s / 100 ms / 10 ms / 1 ms), the other cycles the pattern mode. It sits between the board keys and the LED pins and replaces free-running per-pattern LED logic with one scheduled step engine.

## Interface
- T1S, 50_000_000, step period in cycles, speed 0
- T100MS, 5_000_000, step period, speed 1
- T10MS, 500_000, step period, speed 2
- T1MS, 50_000, step period, speed 3
- DEBOUNCE_CYC, 500_000, cycles a key level must stay stable (10 ms at 50 MHz)
- CLOCK  in  1  system clock, all logic on rising edge
- RESET  in  1  asynchronous, active-high reset
- KEY_SPEED  in  1  active-low button, asynchronous to CLOCK
- KEY_MODE  in  1  active-low button, asynchronous to CLOCK
- PAUSE  in  1  level, high freezes stepping
- LED  out  4  registered LED drive, 1 = on
- SPEED  out  2  current speed index
- MODE  out  2  current mode index
- STEP  out  1  one-cycle pulse on each pattern advance

## Operation
- Reset values: LED=4'b0001, SPEED=0, MODE=0, STEP=0, step counter C=0, ping-pong dir=up, key FSMs IDLE.
- Step period T = T1S/T100MS/T10MS/T1MS for SPEED 0/1/2/3. C is 26 bits and counts 0..T-1. At C==T-1: C<=0, STEP<=1, pattern advances. Otherwise C<=C+1 and STEP<=0.
- Mode 0 rotate-left: 0001→0010→0100→1000→0001. Initial value 0001.
- Mode 1 rotate-right: 1000→0100→0010→0001→1000. Initial value 1000.
- Mode 2 ping-pong: 0001→0010→0100→1000→0100→0010→0001, period 6. The dir register flips to down on reaching 1000 and to up on reaching 0001. Initial value 0001, dir up.
- Mode 3 blink: 1111↔0000. Initial value 1111.
- Keys: each key passes through a 2-FF synchronizer, then a press detector that yields a one-cycle press pulse per physical press. There is no auto-repeat.
- SPEED press: SPEED<=SPEED+1, wrapping 3→0. C<=0. Pattern is unchanged.
- MODE press: MODE<=MODE+1, wrapping 3→0. LED<=initial value of the new mode. C<=0. dir<=up.
- Simultaneous SPEED and MODE presses in the same cycle: both apply.
- A press coinciding with C==T-1: the press wins. No STEP is issued, there is no advance, and C<=0.
- PAUSE=1: C, LED and dir hold, and STEP=0. Presses are still accepted and update SPEED/MODE/LED as above. On PAUSE falling, counting resumes from the held C.
- RESET asserted mid-sequence: all state returns to reset values immediately, with no completion of pending presses.

## Timing
- All outputs are registered. LED and STEP update on the same edge.
- With speed k, STEP pulses are exactly T_k cycles apart. The first STEP after reset or after any press occurs T_k cycles after C is cleared.
- Key latency with debounce: key low first sampled at edge n → synchronized low at n+2 → press pulse after DEBOUNCE_CYC stable cycles → SPEED/MODE/LED update one edge later.
- Debounce FSM per key:
  - IDLE: on key low, go to CHK_DN with count 0.
  - CHK_DN: if count reaches DEBOUNCE_CYC-1 with key still low, emit press and go to HELD. If key goes high, return to IDLE.
  - HELD: on key high, go to CHK_UP.
  - CHK_UP: after DEBOUNCE_CYC-1 stable-high cycles, go to IDLE. If key goes low, return to HELD.

## Configuration
- LED_SEQ_DEBOUNCE_EN defined: the debounce FSM above is compiled in.
- LED_SEQ_DEBOUNCE_EN undefined: no debounce. A press pulse is the falling edge of the synchronized key, and state updates at edge n+3. DEBOUNCE_CYC is ignored.

## Test plan
Bench overrides: T1S=8, T100MS=4, T10MS=2, T1MS=1, DEBOUNCE_CYC=4.
- Reset, then run 40 cycles → LED 0001,0010,0100,1000,0001 with STEP every 8 cycles. SPEED=0, MODE=0.
- Three SPEED presses, each held 10 cycles → SPEED 1,2,3. At SPEED 3, STEP is high every cycle. A fourth press → SPEED=0.
- MODE press while LED=0100 in mode 0 → MODE=1, LED=1000 on the next edge, then 0100 eight cycles later. Further presses: mode 2 runs 0001..1000..0001 (period 6 steps); mode 3 LED=1111/0000.
- Key bouncing low/high every 2 cycles for 12 cycles, then stable low → exactly one press, SPEED 0→1 only.
- PAUSE=1 for 30 cycles at C=5 → no STEP and LED frozen. Release → next STEP after 3 cycles. A SPEED press and a MODE press in the same cycle, with PAUSE high → both increment.
- RESET pulsed mid-debounce and mid-step → LED=0001, SPEED=0, MODE=0, STEP=0, and no press is registered.

Source files
------------

// File: rtl/led_seq_ctrl.sv
// led_seq_ctrl
// Step engine for a 4-LED running-light display. One step counter schedules
// every pattern advance. Two active-low keys select the step speed and the
// pattern mode.
//
// Build option: define LED_SEQ_DEBOUNCE_EN to compile in the per-key debounce
// FSM and its DEBOUNCE_CYC parameter. Without it, a press is the falling edge
// of the synchronized key.
//
// Ports
//   clk_i        system clock, rising edge
//   rst_i        asynchronous active-high reset
//   key_speed_i  active-low speed key (asynchronous)
//   key_mode_i   active-low mode key (asynchronous)
//   pause_i      high freezes stepping; presses are still accepted
//   led_o        registered LED drive, 1 = on
//   speed_o      speed index: 0..3 = T1S / T100MS / T10MS / T1MS
//   mode_o       0 rotate-left, 1 rotate-right, 2 ping-pong, 3 blink
//   step_o       one-cycle pulse on each pattern advance
//
// Debounce key FSM (LED_SEQ_DEBOUNCE_EN only)
//   state     | meaning
//   KS_IDLE   | key released and stable, waiting for a low level
//   KS_CHK_DN | key low, counting stable-low cycles before accepting the press
//   KS_HELD   | press accepted, waiting for release
//   KS_CHK_UP | key high, counting stable-high cycles before re-arming
module led_seq_ctrl #(
  parameter int T1S          = 50_000_000,
  parameter int T100MS       = 5_000_000,
  parameter int T10MS        = 500_000,
`ifdef LED_SEQ_DEBOUNCE_EN
  parameter int DEBOUNCE_CYC = 500_000,
`endif
  parameter int T1MS         = 50_000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       key_speed_i,
  input  logic       key_mode_i,
  input  logic       pause_i,
  output logic [3:0] led_o,
  output logic [1:0] speed_o,
  output logic [1:0] mode_o,
  output logic       step_o
);

  localparam logic [25:0] TLAST_S0 = 26'(T1S - 1);
  localparam logic [25:0] TLAST_S1 = 26'(T100MS - 1);
  localparam logic [25:0] TLAST_S2 = 26'(T10MS - 1);
  localparam logic [25:0] TLAST_S3 = 26'(T1MS - 1);

  // Key bit 0 = speed, bit 1 = mode. Idle level of both keys is high.
  logic [1:0] key_raw;
  logic [1:0] sync1_q, sync2_q;
  logic [1:0] press_q;

  assign key_raw = {key_mode_i, key_speed_i};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= 2'b11;
      sync2_q <= 2'b11;
    end else begin
      sync1_q <= key_raw;
      sync2_q <= sync1_q;
    end
  end

`ifdef LED_SEQ_DEBOUNCE_EN
  typedef enum logic [1:0] {KS_IDLE, KS_CHK_DN, KS_HELD, KS_CHK_UP} key_state_e;

  localparam int DBW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYC - 1);

  key_state_e     key_st_q [2];
  key_state_e     key_st_d [2];
  logic [DBW-1:0] db_cnt_q [2];
  logic [DBW-1:0] db_cnt_d [2];
  logic [1:0]     press_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < 2; i++) begin
        key_st_q[i] <= KS_IDLE;
        db_cnt_q[i] <= '0;
      end
      press_q <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        key_st_q[i] <= key_st_d[i];
        db_cnt_q[i] <= db_cnt_d[i];
      end
      press_q <= press_d;
    end
  end

  always_comb begin
    press_d = '0;
    for (int i = 0; i < 2; i++) begin
      key_st_d[i] = key_st_q[i];
      db_cnt_d[i] = db_cnt_q[i];
      case (key_st_q[i])
        KS_IDLE: begin
          if (!sync2_q[i]) begin
            key_st_d[i] = KS_CHK_DN;
            db_cnt_d[i] = '0;
          end
        end
        KS_CHK_DN: begin
          if (sync2_q[i]) begin
            key_st_d[i] = KS_IDLE;
          end else if (db_cnt_q[i] == DB_LAST) begin
            key_st_d[i] = KS_HELD;
            press_d[i]  = 1'b1;
          end else begin
            db_cnt_d[i] = db_cnt_q[i] + DBW'(1);
          end
        end
        KS_HELD: begin
          if (sync2_q[i]) begin
            key_st_d[i] = KS_CHK_UP;
            db_cnt_d[i] = '0;
          end
        end
        KS_CHK_UP: begin
          // A low glitch during release falls back to HELD, so it never
          // produces a second press.
          if (!sync2_q[i]) begin
            key_st_d[i] = KS_HELD;
          end else if (db_cnt_q[i] == DB_LAST) begin
            key_st_d[i] = KS_IDLE;
          end else begin
            db_cnt_d[i] = db_cnt_q[i] + DBW'(1);
          end
        end
        default: key_st_d[i] = KS_IDLE;
      endcase
    end
  end
`else
  logic [1:0] sync3_q;

  // Press pulse is registered so the state update lands one edge after the
  // synchronized falling edge is seen.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync3_q <= 2'b11;
      press_q <= '0;
    end else begin
      sync3_q <= sync2_q;
      press_q <= sync3_q & ~sync2_q;
    end
  end
`endif

  logic [25:0] c_q, c_d;
  logic [3:0]  led_q, led_d;
  logic [1:0]  speed_q, speed_d;
  logic [1:0]  mode_q, mode_d;
  logic        dir_q, dir_d;        // ping-pong direction, 0 = up
  logic        step_q, step_d;
  logic [25:0] t_last;
  logic [3:0]  led_adv;
  logic        dir_adv;
  logic [1:0]  mode_nx;

  function automatic logic [3:0] mode_init(input logic [1:0] m);
    case (m)
      2'd1:    return 4'b1000;
      2'd3:    return 4'b1111;
      default: return 4'b0001;
    endcase
  endfunction

  always_comb begin
    case (speed_q)
      2'd0:    t_last = TLAST_S0;
      2'd1:    t_last = TLAST_S1;
      2'd2:    t_last = TLAST_S2;
      default: t_last = TLAST_S3;
    endcase
  end

  always_comb begin
    led_adv = led_q;
    dir_adv = dir_q;
    case (mode_q)
      2'd0: led_adv = {led_q[2:0], led_q[3]};
      2'd1: led_adv = {led_q[0], led_q[3:1]};
      2'd2: begin
        led_adv = dir_q ? (led_q >> 1) : (led_q << 1);
        // Turn around on reaching either end so the end LED is shown once.
        if (led_adv == 4'b1000) begin
          dir_adv = 1'b1;
        end else if (led_adv == 4'b0001) begin
          dir_adv = 1'b0;
        end
      end
      default: led_adv = ~led_q;
    endcase
  end

  assign mode_nx = mode_q + 2'd1;

  always_comb begin
    c_d     = c_q;
    led_d   = led_q;
    speed_d = speed_q;
    mode_d  = mode_q;
    dir_d   = dir_q;
    step_d  = 1'b0;
    // A press takes priority over a terminal count, and it is accepted even
    // while paused.
    if (press_q[0] || press_q[1]) begin
      c_d = '0;
      if (press_q[0]) begin
        speed_d = speed_q + 2'd1;
      end
      if (press_q[1]) begin
        mode_d = mode_nx;
        led_d  = mode_init(mode_nx);
        dir_d  = 1'b0;
      end
    end else if (!pause_i) begin
      if (c_q == t_last) begin
        c_d    = '0;
        step_d = 1'b1;
        led_d  = led_adv;
        dir_d  = dir_adv;
      end else begin
        c_d = c_q + 26'd1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      c_q     <= '0;
      led_q   <= 4'b0001;
      speed_q <= '0;
      mode_q  <= '0;
      dir_q   <= 1'b0;
      step_q  <= 1'b0;
    end else begin
      c_q     <= c_d;
      led_q   <= led_d;
      speed_q <= speed_d;
      mode_q  <= mode_d;
      dir_q   <= dir_d;
      step_q  <= step_d;
    end
  end

  assign led_o   = led_q;
  assign speed_o = speed_q;
  assign mode_o  = mode_q;
  assign step_o  = step_q;

endmodule
